sram_line_reader: RTL and testbench
===================================

# sram_line_reader

Read-side requester for the SRAM mux. On a `line_start` pulse it fetches `LINE_WORDS` consecutive 16-bit words from SRAM, starting at `base_addr`, through one client port of the mux (start/rw/addr/data/ready group). It buffers the words in an internal FIFO and presents them to the pixel/display logic as a valid/ready stream. It is the consumer end of the request protocol served by the SRAM controller, and runs in the SRAM controller clock domain.

## Interface
Parameters:
- `LINE_WORDS`, default 160: words fetched per line (1..65535).
- `FIFO_DEPTH`, default 16: FIFO entries, power of two, at least 2.

Ports:
- `clk`  in  1  SRAM controller clock, the single clock of this block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `line_start`  in  1  one-cycle pulse that begins a line fetch.
- `base_addr`  in  16  first word address, sampled with `line_start`.
- `busy`  out  1  high while a line fetch is in progress.
- `line_done`  out  1  one-cycle pulse when the last word of a line is written into the FIFO.
- `overrun_err`  out  1  sticky; set by a `line_start` that arrives while `busy`; cleared only by reset.
- `sram_start_n`  out  1  active-low request strobe, one cycle wide.
- `sram_rw`  out  1  1 = read. Constant 1.
- `sram_addr`  out  16  request address.
- `sram_data`  out  16  write data. Constant 0.
- `sram_ready`  in  1  controller idle / transaction complete.
- `sram_data_in`  in  16  read data, valid in the cycle `sram_ready` rises.
- `pix_data`  out  16  FIFO head word.
- `pix_valid`  out  1  FIFO not empty.
- `pix_ready`  in  1  consumer accepts `pix_data` this cycle.

## Operation
- FSM states: IDLE, REQ, WAIT_ACK, WAIT_DONE.
- IDLE: on `line_start`, load the address counter from `base_addr`, load the word counter with `LINE_WORDS`, set `busy`, and go to REQ. A `line_start` in any other state is ignored and sets `overrun_err`.
- REQ: issue a request only if `sram_ready`=1 and (FIFO count + 1) ≤ `FIFO_DEPTH`. Otherwise hold in REQ with `sram_start_n`=1. When issuing, drive `sram_start_n`=0 for exactly that cycle, put the counter value on `sram_addr`, and go to WAIT_ACK.
- WAIT_ACK: wait for `sram_ready`=0, then go to WAIT_DONE. `sram_addr` is held stable.
- WAIT_DONE: on `sram_ready`=1, push `sram_data_in` into the FIFO, increment the address, and decrement the word counter.
  - If the word counter reaches 0: pulse `line_done`, clear `busy`, go to IDLE.
  - Otherwise go to REQ.
- At most one request is outstanding. Because the space check happens before issuing, the FIFO never overflows; a push while full cannot occur.
- Address arithmetic is 16-bit unsigned with wrap-around: 0xFFFF + 1 = 0x0000.
- FIFO is first-word-fall-through. `pix_valid` = not empty. A pop happens when `pix_valid` & `pix_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - A pop while empty is a no-op.
- FIFO contents persist across lines. `line_start` does not flush the FIFO.

## Timing
- Reset values: `busy`=0, `line_done`=0, `overrun_err`=0, `sram_start_n`=1, `sram_rw`=1, `sram_addr`=0, `sram_data`=0, `pix_valid`=0, `pix_data`=0. FSM resets to IDLE, FIFO resets to empty, counters reset to 0.
- An assertion of `reset_n` mid-transaction aborts immediately:
  - Outputs take their reset values asynchronously.
  - The in-flight read result is discarded.
  - A new `line_start` is accepted in the first cycle after reset is released.
- `line_start` is sampled at edge N. `busy`=1 from N+1, and `sram_start_n` can go low at N+1 at the earliest.
- A word pushed at edge M gives `pix_valid`=1 from M+1.
- Minimum issue spacing is 3 cycles plus the controller's ready-low duration.
- All outputs are registered.

## Structure
- Package `sram_if_pkg` holds `SRAM_RW_READ`=1'b1, `SRAM_RW_WRITE`=1'b0, `SRAM_ADDR_W`=16, `SRAM_DATA_W`=16, and the reader state enum. The package is shared with the mux and the other requesters.
- Sub-module `sync_fifo`: parameterised width and depth, first-word-fall-through, with count output. It is instantiated once here.

## Test plan
- Reset: hold `reset_n`=0 → `sram_start_n`=1, `busy`=0, `pix_valid`=0, `overrun_err`=0.
- `LINE_WORDS`=4, `base_addr`=0x0100. SRAM model returns addr^0xA5A5, `pix_ready`=1 → requests go to 0x0100–0x0103, the stream is 0xA4A5, 0xA4A4, 0xA4A7, 0xA4A6, there is exactly one `line_done` pulse, and `busy` drops the cycle after it.
- Backpressure: `LINE_WORDS`=20, `FIFO_DEPTH`=16, `pix_ready`=0 → exactly 16 `sram_start_n` pulses, then none. After `pix_ready`=1, 4 further requests occur and 20 words arrive in order.
- Wrap: `base_addr`=0xFFFE, `LINE_WORDS`=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `line_start` while `busy` → `overrun_err`=1 and stays 1; the address sequence of the current line is unchanged.
- Reset asserted during WAIT_DONE → `sram_start_n`=1 and the FIFO is empty. After release, `line_start` with base 0x0200 fetches from 0x0200.

Source files
------------

// File: rtl/sram_if_pkg.sv
// rtl/sram_if_pkg.sv - shared SRAM request-port constants and reader state type
package sram_if_pkg;

  localparam logic SRAM_RW_READ  = 1'b1;
  localparam logic SRAM_RW_WRITE = 1'b0;
  localparam int   SRAM_ADDR_W   = 16;
  localparam int   SRAM_DATA_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    WAIT_DONE
  } reader_state_e;

endpackage

// File: rtl/sram_line_reader_if.sv
// rtl/sram_line_reader_if.sv - SRAM mux client port plus pixel stream of the line reader
interface sram_line_reader_if;
  import sram_if_pkg::*;

  logic                   sram_start_n;
  logic                   sram_rw;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [SRAM_DATA_W-1:0] sram_data;
  logic                   sram_ready;
  logic [SRAM_DATA_W-1:0] sram_data_in;

  logic [SRAM_DATA_W-1:0] pix_data;
  logic                   pix_valid;
  logic                   pix_ready;

  modport master (
    output sram_start_n, sram_rw, sram_addr, sram_data, pix_data, pix_valid,
    input  sram_ready, sram_data_in, pix_ready
  );

  modport slave (
    input  sram_start_n, sram_rw, sram_addr, sram_data, pix_data, pix_valid,
    output sram_ready, sram_data_in, pix_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with registered head, valid and count
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] head_next;

  assign pop  = rd_en && valid;
  assign push = wr_en && ((count != FULL_CNT) || pop);

  // Head is kept in its own register so the stream output never passes through the read mux.
  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + ONE_CNT;
    else if (!push && pop)
      count_next = count - ONE_CNT;

    head_next = rd_data;
    if (pop && (count > ONE_CNT))
      head_next = mem[rd_ptr + AW'(1)];
    else if (push && ((count == '0) || (pop && (count == ONE_CNT))))
      head_next = wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid   <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      valid   <= (count_next != '0);
      rd_data <= head_next;
    end
  end

endmodule

// File: rtl/sram_line_reader.sv
// rtl/sram_line_reader.sv - fetches one line of SRAM words into a FIFO and streams them out
module sram_line_reader
  import sram_if_pkg::*;
#(
  parameter int LINE_WORDS = 160,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   line_start,
  input  logic [SRAM_ADDR_W-1:0] base_addr,
  output logic                   busy,
  output logic                   line_done,
  output logic                   overrun_err,
  sram_line_reader_if.master     bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      WORDS     = 16'(LINE_WORDS);

  reader_state_e          state;
  logic [SRAM_ADDR_W-1:0] addr_cnt;
  logic [15:0]            word_cnt;
  logic [CNT_W-1:0]       fifo_count;
  logic                   push;

  assign push          = (state == WAIT_DONE) && bus.sram_ready;
  assign bus.sram_rw   = SRAM_RW_READ;
  assign bus.sram_data = '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      addr_cnt         <= '0;
      word_cnt         <= '0;
      busy             <= 1'b0;
      line_done        <= 1'b0;
      overrun_err      <= 1'b0;
      bus.sram_start_n <= 1'b1;
      bus.sram_addr    <= '0;
    end else begin
      line_done        <= 1'b0;
      bus.sram_start_n <= 1'b1;
      if (line_start && (state != IDLE))
        overrun_err <= 1'b1;

      case (state)
        IDLE: begin
          if (line_start) begin
            addr_cnt <= base_addr;
            word_cnt <= WORDS;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        // Space is reserved before issuing, so the returning word always fits.
        REQ: begin
          if (bus.sram_ready && (fifo_count < FIFO_FULL)) begin
            bus.sram_start_n <= 1'b0;
            bus.sram_addr    <= addr_cnt;
            state            <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!bus.sram_ready)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.sram_ready) begin
            addr_cnt <= addr_cnt + 16'd1;
            word_cnt <= word_cnt - 16'd1;
            if (word_cnt == 16'd1) begin
              line_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (SRAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (bus.sram_data_in),
    .rd_en   (bus.pix_ready),
    .rd_data (bus.pix_data),
    .valid   (bus.pix_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_sram_line_reader.sv
// tb/tb_sram_line_reader.sv - randomized self-checking bench for sram_line_reader
module tb_sram_line_reader;

  localparam int LW = 4;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [15:0] base_addr = 16'h0;
  logic        busy, line_done, overrun_err;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int ld_cnt = 0;
  int lat_min = 1;
  int lat_max = 3;
  logic [15:0] exp_q[$];
  logic [15:0] expa_q[$];
  logic [15:0] got_q[$];
  logic [15:0] req_q[$];

  sram_line_reader_if bus ();

  sram_line_reader #(.LINE_WORDS(LW), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .line_start  (line_start),
    .base_addr   (base_addr),
    .busy        (busy),
    .line_done   (line_done),
    .overrun_err (overrun_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Controller model: accepts a strobe while idle, drops ready, returns addr^0xA5A5 later.
  initial begin : sram_model
    logic [15:0] a;
    bus.sram_ready   = 1'b1;
    bus.sram_data_in = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (!bus.sram_start_n && bus.sram_ready) begin
        a = bus.sram_addr;
        bus.sram_ready   = 1'b0;
        bus.sram_data_in = 16'hDEAD;
        repeat ($urandom_range(lat_min, lat_max)) @(posedge clk);
        #1;
        bus.sram_data_in = a ^ 16'hA5A5;
        bus.sram_ready   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (!bus.sram_start_n) begin
        pulses++;
        req_q.push_back(bus.sram_addr);
      end
      if (line_done) ld_cnt++;
      if (bus.pix_valid && bus.pix_ready) got_q.push_back(bus.pix_data);
    end
  end

  task automatic clear_logs();
    exp_q.delete(); expa_q.delete(); got_q.delete(); req_q.delete();
    pulses = 0; ld_cnt = 0;
  endtask

  task automatic start_line(input logic [15:0] b);
    @(posedge clk); #1;
    line_start = 1'b1;
    base_addr  = b;
    for (int i = 0; i < LW; i++) begin
      expa_q.push_back(b + 16'(i));
      exp_q.push_back((b + 16'(i)) ^ 16'hA5A5);
    end
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rnd) bus.pix_ready = 1'($urandom_range(0, 1));
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drain(output bit ok);
    bus.pix_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (!bus.pix_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.sram_start_n !== 1'b1) begin errors++; $display("FAIL reset_start_n got %b want 1", bus.sram_start_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %b want 0", bus.pix_valid); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun_err); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_line_done got %b want 0", line_done); end
    checks++; if ({bus.sram_rw, bus.sram_addr, bus.sram_data, bus.pix_data} !== {1'b1, 48'h0})
      begin errors++; $display("FAIL reset_bus got rw=%b addr=%h data=%h pix=%h want 1/0/0/0", bus.sram_rw, bus.sram_addr, bus.sram_data, bus.pix_data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic_line();
    logic [15:0] want[LW] = '{16'hA4A5, 16'hA4A4, 16'hA4A7, 16'hA4A6};
    bit ok;
    clear_logs();
    bus.pix_ready = 1'b1;
    start_line(16'h0100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", busy); end
    wait_idle(500, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout busy got 1 want 0"); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_done got %b want 0", busy); end
    drain(ok);
    checks++; if (ld_cnt !== 1) begin errors++; $display("FAIL basic_line_done_count got %0d want 1", ld_cnt); end
    checks++; if (got_q.size() !== LW) begin errors++; $display("FAIL basic_stream_len got %0d want %0d", got_q.size(), LW); end
    else for (int i = 0; i < LW; i++) begin
      checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, got_q[i], want[i]); end
    end
    checks++; if (req_q.size() !== LW) begin errors++; $display("FAIL basic_req_count got %0d want %0d", req_q.size(), LW); end
    else for (int i = 0; i < LW; i++) begin
      checks++; if (req_q[i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL basic_addr%0d got %h want %h", i, req_q[i], 16'h0100 + 16'(i)); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want[LW] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bit ok;
    clear_logs();
    start_line(16'hFFFE);
    wait_idle(500, 1'b0, ok);
    drain(ok);
    checks++; if (req_q.size() !== LW) begin errors++; $display("FAIL wrap_req_count got %0d want %0d", req_q.size(), LW); end
    else for (int i = 0; i < LW; i++) begin
      checks++; if (req_q[i] !== want[i]) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, req_q[i], want[i]); end
    end
    checks++; if (got_q.size() > 0 && got_q[2] !== 16'hA5A5) begin errors++; $display("FAIL wrap_word2 got %h want a5a5", got_q[2]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    bus.pix_ready = 1'b0;
    for (int l = 0; l < 4; l++) begin
      start_line(16'($urandom));
      wait_idle(500, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_line%0d_timeout busy got 1 want 0", l); end
    end
    start_line(16'($urandom));
    repeat (100) @(posedge clk);
    #1;
    checks++; if (pulses !== FD) begin errors++; $display("FAIL bp_stall_pulses got %0d want %0d", pulses, FD); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_stall_busy got %b want 1", busy); end
    checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got %b want 1", bus.pix_valid); end
    bus.pix_ready = 1'b1;
    wait_idle(1000, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_resume_timeout busy got 1 want 0"); end
    drain(ok);
    checks++; if (pulses !== 5 * LW) begin errors++; $display("FAIL bp_total_pulses got %0d want %0d", pulses, 5 * LW); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_stream_len got %0d want %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_stream();
    bit ok;
    clear_logs();
    for (int l = 0; l < 6; l++) begin
      start_line(16'($urandom));
      wait_idle(2000, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_line%0d_timeout busy got 1 want 0", l); end
    end
    drain(ok);
    checks++; if (ld_cnt !== 6) begin errors++; $display("FAIL rand_line_done_count got %0d want 6", ld_cnt); end
    checks++; if (req_q.size() !== expa_q.size()) begin errors++; $display("FAIL rand_req_count got %0d want %0d", req_q.size(), expa_q.size()); end
    else for (int i = 0; i < expa_q.size(); i++) begin
      checks++; if (req_q[i] !== expa_q[i]) begin errors++; $display("FAIL rand_addr%0d got %h want %h", i, req_q[i], expa_q[i]); end
    end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_stream_len got %0d want %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    clear_logs();
    bus.pix_ready = 1'b1;
    start_line(16'h3000);
    repeat (3) @(posedge clk);
    #1;
    line_start = 1'b1;
    base_addr  = 16'h7777;
    @(posedge clk); #1;
    line_start = 1'b0;
    checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun_err); end
    wait_idle(500, 1'b0, ok);
    repeat (20) @(posedge clk);
    #1;
    drain(ok);
    checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", overrun_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_no_new_line got busy %b want 0", busy); end
    checks++; if (req_q.size() !== LW) begin errors++; $display("FAIL overrun_req_count got %0d want %0d", req_q.size(), LW); end
    else for (int i = 0; i < LW; i++) begin
      checks++; if (req_q[i] !== expa_q[i]) begin errors++; $display("FAIL overrun_addr%0d got %h want %h", i, req_q[i], expa_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    bus.pix_ready = 1'b0;
    lat_min = 4;
    lat_max = 4;
    start_line(16'h0500);
    for (int i = 0; i < 300 && pulses < 3; i++) @(posedge clk);
    for (int i = 0; i < 20 && bus.sram_ready; i++) @(negedge clk);
    @(posedge clk); #2;
    checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL rmid_prefill_valid got %b want 1", bus.pix_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.sram_start_n !== 1'b1) begin errors++; $display("FAIL rmid_start_n got %b want 1", bus.sram_start_n); end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL rmid_fifo_empty got valid %b want 0", bus.pix_valid); end
    checks++; if ({busy, overrun_err} !== 2'b00) begin errors++; $display("FAIL rmid_flags got busy/overrun %b want 00", {busy, overrun_err}); end
    @(posedge clk); #1;
    clear_logs();
    lat_min = 1;
    lat_max = 3;
    reset_n    = 1'b1;
    line_start = 1'b1;
    base_addr  = 16'h0200;
    for (int i = 0; i < LW; i++) begin
      expa_q.push_back(16'h0200 + 16'(i));
      exp_q.push_back((16'h0200 + 16'(i)) ^ 16'hA5A5);
    end
    @(posedge clk); #1;
    line_start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_restart_busy got %b want 1", busy); end
    wait_idle(500, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout busy got 1 want 0"); end
    drain(ok);
    checks++; if (req_q.size() !== LW) begin errors++; $display("FAIL rmid_req_count got %0d want %0d", req_q.size(), LW); end
    else for (int i = 0; i < LW; i++) begin
      checks++; if (req_q[i] !== expa_q[i]) begin errors++; $display("FAIL rmid_addr%0d got %h want %h", i, req_q[i], expa_q[i]); end
    end
    checks++; if (got_q.size() !== LW) begin errors++; $display("FAIL rmid_stream_len got %0d want %0d", got_q.size(), LW); end
    else for (int i = 0; i < LW; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_word%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    bus.pix_ready = 1'b0;
    test_reset();
    test_basic_line();
    test_wrap();
    test_backpressure();
    test_random_stream();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
